// File: rtl/battle_pkg.sv
// Shared types and keycodes for the battle screen: phase and menu encodings
// plus the HID keycodes the menu logic responds to.
`timescale 1ns/1ps
package battle_pkg;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_MENU   = 3'd1,
    PH_TEXT   = 3'd2,
    PH_ATTACK = 3'd3,
    PH_WIN    = 3'd4,
    PH_SPARED = 3'd5,
    PH_LOSE   = 3'd6
  } phase_t;

  typedef enum logic [1:0] {
    SEL_FIGHT = 2'd0,
    SEL_ACT   = 2'd1,
    SEL_ITEM  = 2'd2,
    SEL_MERCY = 2'd3
  } menu_t;

  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_Z     = 8'h1D;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  function automatic logic is_confirm(input logic [7:0] k);
    return (k == KEY_Z) || (k == KEY_ENTER);
  endfunction

endpackage

// File: rtl/battle_turn_ctrl_key_press_detect.sv
// Turns a level keycode into a one-cycle press event: fires when a nonzero
// code differs from last cycle's code, so holds fire once and rollovers fire.
`timescale 1ns/1ps
module key_press_detect (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       press,
  output logic [7:0] press_code
);

  logic [7:0] prev_key;

  always_ff @(posedge Clk) begin
    if (Reset) prev_key <= 8'h00;
    else       prev_key <= keycode;
  end

  assign press      = (keycode != 8'h00) && (keycode != prev_key);
  assign press_code = keycode;

endmodule

// File: rtl/battle_turn_ctrl.sv
// Battle encounter sequencer: command menu, action text, timed enemy attack and
// win/spare/lose resolution. The phase output is the FSM state itself.
`timescale 1ns/1ps
module battle_turn_ctrl
  import battle_pkg::*;
#(
  parameter int unsigned PLAYER_HP_MAX = 20,
  parameter int unsigned ENEMY_HP_INIT = 40,
  parameter int unsigned FIGHT_DMG     = 6,
  parameter int unsigned HEAL_AMT      = 8,
  parameter int unsigned ITEM_COUNT    = 3,
  parameter int unsigned TEXT_FRAMES   = 90,
  parameter int unsigned ATTACK_FRAMES = 300
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       battle_start,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       hit,
  output logic [2:0] phase,
  output logic [1:0] menu_sel,
  output logic [4:0] player_hp,
  output logic [7:0] enemy_hp,
  output logic [1:0] items_left,
  output logic       attack_active,
  output logic       battle_done
);

  localparam logic [4:0] HP_MAX      = 5'(PLAYER_HP_MAX);
  localparam logic [7:0] E_INIT      = 8'(ENEMY_HP_INIT);
  localparam logic [7:0] SPARE_HP    = 8'(ENEMY_HP_INIT / 4);
  localparam logic [1:0] ITEMS_INIT  = 2'(ITEM_COUNT);
  localparam logic [8:0] TEXT_LAST   = 9'(TEXT_FRAMES - 1);
  localparam logic [8:0] ATTACK_LAST = 9'(ATTACK_FRAMES - 1);

  phase_t     state;
  menu_t      sel_q;
  logic [8:0] frame_cnt;
  logic       press;
  logic [7:0] press_code;

  key_press_detect u_keys (
    .Clk        (Clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .press      (press),
    .press_code (press_code)
  );

  // HP arithmetic runs one bit wide so under/overflow shows up in the top bit.
  logic [8:0] enemy_sub;
  logic [7:0] enemy_after_fight;
  logic [5:0] heal_sum;
  logic [4:0] hp_after_heal;
  logic [5:0] hit_sub;
  logic       hit_kills;

  assign enemy_sub         = {1'b0, enemy_hp} - 9'(FIGHT_DMG);
  assign enemy_after_fight = enemy_sub[8] ? 8'd0 : enemy_sub[7:0];
  assign heal_sum          = {1'b0, player_hp} + 6'(HEAL_AMT);
  assign hp_after_heal     = (heal_sum > {1'b0, HP_MAX}) ? HP_MAX : heal_sum[4:0];
  assign hit_sub           = {1'b0, player_hp} - 6'd1;
  assign hit_kills         = hit_sub[5] || (hit_sub == 6'd0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= PH_IDLE;
      sel_q         <= SEL_FIGHT;
      player_hp     <= HP_MAX;
      enemy_hp      <= E_INIT;
      items_left    <= ITEMS_INIT;
      frame_cnt     <= 9'd0;
      attack_active <= 1'b0;
      battle_done   <= 1'b0;
    end else begin
      battle_done <= 1'b0;
      case (state)
        PH_IDLE: begin
          if (battle_start) begin
            player_hp  <= HP_MAX;
            enemy_hp   <= E_INIT;
            items_left <= ITEMS_INIT;
            sel_q      <= SEL_FIGHT;
            state      <= PH_MENU;
          end
        end
        PH_MENU: begin
          if (press) begin
            if (press_code == KEY_LEFT) begin
              sel_q <= menu_t'(sel_q - 2'd1);
            end else if (press_code == KEY_RIGHT) begin
              sel_q <= menu_t'(sel_q + 2'd1);
            end else if (is_confirm(press_code)) begin
              state     <= PH_TEXT;
              frame_cnt <= 9'd0;
              case (sel_q)
                SEL_FIGHT: enemy_hp <= enemy_after_fight;
                SEL_ITEM: begin
                  if (items_left != 2'd0) begin
                    player_hp  <= hp_after_heal;
                    items_left <= items_left - 2'd1;
                  end
                end
                SEL_MERCY: begin
                  if (enemy_hp <= SPARE_HP) begin
                    state       <= PH_SPARED;
                    battle_done <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        PH_TEXT: begin
          if (frame_tick) begin
            if (frame_cnt == TEXT_LAST) begin
              frame_cnt <= 9'd0;
              if (enemy_hp == 8'd0) begin
                state       <= PH_WIN;
                battle_done <= 1'b1;
              end else begin
                state         <= PH_ATTACK;
                attack_active <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 9'd1;
            end
          end
        end
        PH_ATTACK: begin
          // A fatal hit wins over the timer expiring in the same cycle.
          if (hit && hit_kills) begin
            player_hp     <= 5'd0;
            state         <= PH_LOSE;
            attack_active <= 1'b0;
            battle_done   <= 1'b1;
          end else begin
            if (hit) player_hp <= hit_sub[4:0];
            if (frame_tick) begin
              if (frame_cnt == ATTACK_LAST) begin
                frame_cnt     <= 9'd0;
                state         <= PH_MENU;
                attack_active <= 1'b0;
              end else begin
                frame_cnt <= frame_cnt + 9'd1;
              end
            end
          end
        end
        PH_WIN, PH_SPARED, PH_LOSE: begin
          if (press && is_confirm(press_code)) state <= PH_IDLE;
        end
        default: state <= PH_IDLE;
      endcase
    end
  end

  assign phase    = state;
  assign menu_sel = sel_q;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Self-checking bench for battle_turn_ctrl: menu navigation vectors, then full
// encounters covering fight/win, item use, lose-on-final-tick, mercy and reset.
`timescale 1ns/1ps
module tb_battle_turn_ctrl;
  import battle_pkg::*;

  typedef struct packed {
    logic [2:0] ph;
    logic [1:0] sel;
    logic [4:0] php;
    logic [7:0] ehp;
    logic [1:0] it;
    logic       aa;
    logic       bd;
  } out_t;

  typedef struct packed {
    logic [7:0] key;
    logic       st;
    logic       tk;
    logic       ht;
    logic [2:0] ph;
    logic [1:0] sel;
  } vec_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       battle_start = 1'b0;
  logic       frame_tick = 1'b0;
  logic       hit = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [2:0] phase;
  logic [1:0] menu_sel;
  logic [4:0] player_hp;
  logic [7:0] enemy_hp;
  logic [1:0] items_left;
  logic       attack_active;
  logic       battle_done;

  battle_turn_ctrl dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .battle_start  (battle_start),
    .frame_tick    (frame_tick),
    .keycode       (keycode),
    .hit           (hit),
    .phase         (phase),
    .menu_sel      (menu_sel),
    .player_hp     (player_hp),
    .enemy_hp      (enemy_hp),
    .items_left    (items_left),
    .attack_active (attack_active),
    .battle_done   (battle_done)
  );

  // clock and watchdog
  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [21:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  out_t e;
  vec_t vecs[12];

  function automatic out_t fresh(input logic [2:0] ph);
    out_t r;
    r.ph = ph; r.sel = 2'd0; r.php = 5'd20; r.ehp = 8'd40;
    r.it = 2'd3; r.aa = 1'b0; r.bd = 1'b0;
    return r;
  endfunction

  // drivers
  task automatic step(input logic [7:0] k, input logic st, input logic tk,
                      input logic ht, input logic chk, input string name);
    out_t act;
    out_t want;
    keycode = k; battle_start = st; frame_tick = tk; hit = ht;
    if (chk) exp_q.push_back(e);
    @(posedge Clk);
    #1;
    battle_start = 1'b0; frame_tick = 1'b0; hit = 1'b0;
    if (chk) begin
      want = out_t'(exp_q.pop_front());
      act = {phase, menu_sel, player_hp, enemy_hp, items_left, attack_active, battle_done};
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL %s: got ph=%0d sel=%0d php=%0d ehp=%0d it=%0d aa=%0d bd=%0d, want ph=%0d sel=%0d php=%0d ehp=%0d it=%0d aa=%0d bd=%0d",
                 name, act.ph, act.sel, act.php, act.ehp, act.it, act.aa, act.bd,
                 want.ph, want.sel, want.php, want.ehp, want.it, want.aa, want.bd);
      end
    end
  endtask

  task automatic tap(input logic [7:0] k, input string name);
    step(k, 1'b0, 1'b0, 1'b0, 1'b1, name);
    e.bd = 1'b0;
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, {name, "_rel"});
  endtask

  task automatic run_text(input logic win);
    for (int i = 0; i < 89; i++) step(8'h00, 1'b0, 1'b1, 1'b0, i == 88, "text_hold");
    if (win) begin
      e.ph = 3'd4; e.bd = 1'b1;
    end else begin
      e.ph = 3'd3; e.aa = 1'b1;
    end
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, "text_exp");
    e.bd = 1'b0;
    if (win) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "done_once");
  endtask

  task automatic run_attack(input int n_hits);
    for (int i = 0; i < n_hits; i++) begin
      e.php = e.php - 5'd1;
      step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "hit");
    end
    for (int i = 0; i < 299; i++) step(8'h00, 1'b0, 1'b1, 1'b0, i == 298, "atk_hold");
    e.ph = 3'd1; e.aa = 1'b0;
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, "atk_exp");
  endtask

  task automatic fight();
    e.ehp = (e.ehp > 8'd6) ? e.ehp - 8'd6 : 8'd0;
    e.ph = 3'd2;
    tap(KEY_Z, "fight");
    run_text(e.ehp == 8'd0);
    if (e.ehp != 8'd0) run_attack(0);
  endtask

  initial begin
    vecs[0]  = '{KEY_Z,     1'b0, 1'b0, 1'b0, 3'd0, 2'd0};
    vecs[1]  = '{8'h00,     1'b1, 1'b0, 1'b0, 3'd1, 2'd0};
    vecs[2]  = '{KEY_LEFT,  1'b0, 1'b0, 1'b0, 3'd1, 2'd3};
    vecs[3]  = '{8'h00,     1'b0, 1'b0, 1'b0, 3'd1, 2'd3};
    vecs[4]  = '{8'h04,     1'b0, 1'b0, 1'b0, 3'd1, 2'd3};
    vecs[5]  = '{8'h00,     1'b0, 1'b1, 1'b1, 3'd1, 2'd3};
    vecs[6]  = '{KEY_LEFT,  1'b0, 1'b0, 1'b0, 3'd1, 2'd3};
    vecs[7]  = '{KEY_LEFT,  1'b0, 1'b0, 1'b0, 3'd1, 2'd3};
    vecs[8]  = '{8'h00,     1'b0, 1'b0, 1'b0, 3'd1, 2'd3};
    vecs[9]  = '{KEY_LEFT,  1'b0, 1'b0, 1'b0, 3'd1, 2'd2};
    vecs[10] = '{KEY_RIGHT, 1'b0, 1'b0, 1'b0, 3'd1, 2'd3};
    vecs[11] = '{8'h00,     1'b0, 1'b0, 1'b0, 3'd1, 2'd3};

    // reset
    e = fresh(3'd0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "reset_pre");
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
    Reset = 1'b0;

    // menu navigation vectors, with a held Right after vector 5
    for (int i = 0; i < 12; i++) begin
      e.ph = vecs[i].ph; e.sel = vecs[i].sel;
      step(vecs[i].key, vecs[i].st, vecs[i].tk, vecs[i].ht, 1'b1, $sformatf("vec%0d", i));
      if (i == 5) begin
        e.sel = 2'd0;
        for (int j = 0; j < 10; j++) step(KEY_RIGHT, 1'b0, 1'b0, 1'b0, 1'b1, "hold_right");
      end
    end

    // battle 1: seven fights to a win
    e.sel = 2'd0;
    tap(KEY_RIGHT, "to_fight");
    for (int i = 0; i < 7; i++) fight();
    step(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "win_start_ignored");
    e.ph = 3'd0;
    tap(KEY_Z, "win_exit");

    // battle 2: items, then lose on the final attack tick
    e = fresh(3'd1);
    step(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "start2");
    e.sel = 2'd1;
    tap(KEY_RIGHT, "to_act");
    e.ph = 3'd2;
    tap(KEY_Z, "act");
    run_text(1'b0);
    run_attack(5);
    e.sel = 2'd2;
    tap(KEY_RIGHT, "to_item");
    e.ph = 3'd2; e.php = 5'd20; e.it = 2'd2;
    tap(KEY_ENTER, "item1");
    run_text(1'b0);
    run_attack(0);
    e.ph = 3'd2; e.php = 5'd20; e.it = 2'd1;
    tap(KEY_Z, "item2");
    run_text(1'b0);
    run_attack(10);
    e.ph = 3'd2; e.php = 5'd18; e.it = 2'd0;
    tap(KEY_Z, "item3");
    run_text(1'b0);
    run_attack(2);
    e.ph = 3'd2;
    tap(KEY_Z, "item4_empty");
    run_text(1'b0);
    for (int i = 0; i < 15; i++) begin
      e.php = e.php - 5'd1;
      step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "hit_to_one");
    end
    for (int i = 0; i < 299; i++) step(8'h00, 1'b0, 1'b1, 1'b0, i == 298, "atk_hold_lose");
    e.ph = 3'd6; e.php = 5'd0; e.aa = 1'b0; e.bd = 1'b1;
    step(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, "lose_beats_expiry");
    e.bd = 1'b0;
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "lose_hold");
    e.ph = 3'd0;
    tap(KEY_Z, "lose_exit");

    // battle 3: mercy refused at 16, granted at 10
    e = fresh(3'd1);
    step(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "start3");
    for (int i = 0; i < 4; i++) fight();
    e.sel = 2'd3;
    tap(KEY_LEFT, "to_mercy");
    e.ph = 3'd2;
    tap(KEY_Z, "mercy_refused");
    run_text(1'b0);
    run_attack(0);
    e.sel = 2'd0;
    tap(KEY_RIGHT, "wrap_to_fight");
    fight();
    e.sel = 2'd3;
    tap(KEY_LEFT, "to_mercy2");
    e.ph = 3'd5; e.bd = 1'b1;
    tap(KEY_Z, "mercy_granted");
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "spared_hold");
    e.ph = 3'd0;
    tap(KEY_Z, "spared_exit");

    // battle 4: reset in the middle of an attack, colliding with every input
    e = fresh(3'd1);
    step(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "start4");
    e.ph = 3'd2; e.ehp = 8'd34;
    tap(KEY_Z, "fight4");
    run_text(1'b0);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "atk_tick");
    e.php = 5'd19;
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "hit4");
    Reset = 1'b1;
    e = fresh(3'd0);
    step(KEY_Z, 1'b1, 1'b1, 1'b1, 1'b1, "reset_mid_attack");
    Reset = 1'b0;
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "post_reset");

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/battle_turn_ctrl.md
Name: battle_turn_ctrl

Overview:
- Sequences one battle encounter once the top-level game state enters its battle screen: command menu, action text, timed enemy-attack phase, and win/lose resolution.
- Turns the raw keyboard keycode into single-cycle press events.
- Owns player and enemy HP.
- Drives the phase code consumed by the sprite/text renderers and the bullet-pattern engine.

Parameters:
- PLAYER_HP_MAX, 20, player HP at battle start and heal ceiling (fits 5 bits).
- ENEMY_HP_INIT, 40, enemy HP at battle start (fits 8 bits).
- FIGHT_DMG, 6, enemy HP removed per FIGHT.
- HEAL_AMT, 8, player HP restored per ITEM use.
- ITEM_COUNT, 3, ITEM uses per battle.
- TEXT_FRAMES, 90, frame ticks the action text is shown.
- ATTACK_FRAMES, 300, frame ticks of each enemy-attack phase.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- battle_start  in  1  one-cycle pulse from the game state machine; begins an encounter
- frame_tick  in  1  one-cycle pulse per video frame (vsync)
- keycode  in  8  current USB HID keycode, 0 = none
- hit  in  1  one-cycle pulse from collision logic: soul hit by a bullet
- phase  out  3  0 IDLE, 1 MENU, 2 TEXT, 3 ATTACK, 4 WIN, 5 SPARED, 6 LOSE
- menu_sel  out  2  0 FIGHT, 1 ACT, 2 ITEM, 3 MERCY
- player_hp  out  5  current player HP
- enemy_hp  out  8  current enemy HP
- items_left  out  2  remaining ITEM uses
- attack_active  out  1  high exactly while phase = ATTACK
- battle_done  out  1  one-cycle pulse on entry to WIN, SPARED or LOSE

Behaviour:
- Reset:
  - phase = IDLE, menu_sel = 0, player_hp = PLAYER_HP_MAX, enemy_hp = ENEMY_HP_INIT, items_left = ITEM_COUNT.
  - frame counter = 0, prev_key = 0, attack_active = 0, battle_done = 0.
  - Reset has priority over every other input in the same cycle.
- Key events:
  - prev_key is registered every cycle.
  - A press of K fires in the cycle where keycode = K and prev_key != K and K != 0.
  - A held key fires once. A key change without a release (Left to Right) fires the new key.
- Keys used:
  - Left 8'h50, Right 8'h4F.
  - Confirm Z 8'h1D or Enter 8'h28.
  - Any other keycode is ignored.
- IDLE:
  - battle_start loads HP, items and menu_sel to their reset values, then goes to MENU.
  - Keys are ignored.
- MENU:
  - Left decrements menu_sel and Right increments it, both modulo 4 (0 to 3 on Left, 3 to 0 on Right).
  - Confirm acts on the current menu_sel in the same cycle as the event:
    - FIGHT: enemy_hp -= FIGHT_DMG, saturating at 0.
    - ACT: no effect.
    - ITEM: if items_left > 0, player_hp = min(player_hp + HEAL_AMT, PLAYER_HP_MAX) and items_left -= 1; if 0, no effect (text still shown).
    - MERCY: if enemy_hp <= ENEMY_HP_INIT/4, go to SPARED directly; otherwise no effect.
  - Every Confirm except a successful MERCY goes to TEXT with the frame counter cleared.
- TEXT:
  - The frame counter increments on frame_tick. Keys are ignored.
  - When the counter reaches TEXT_FRAMES-1 on a tick: if enemy_hp = 0 go to WIN, otherwise go to ATTACK with the counter cleared.
- ATTACK:
  - Each hit pulse decrements player_hp by 1, saturating at 0.
  - In the cycle player_hp would reach 0, go to LOSE; this beats timer expiry in the same cycle.
  - On timer expiry (ATTACK_FRAMES-1 reached on a tick), go to MENU with menu_sel kept.
  - hit is ignored in every other phase.
- WIN / SPARED / LOSE:
  - battle_done pulses for the first cycle only.
  - The block holds until Confirm is pressed, then goes to IDLE.
  - battle_start is ignored here and in all non-IDLE phases.
- Widths:
  - Arithmetic is done one bit wider than the target, then clamped.
  - Frame counter is 9 bits.
- Latency:
  - All outputs are registered.
  - An input event is reflected one cycle after the sampling edge.

Decomposition:
- Shared package battle_pkg:
  - phase enum (3 bits) and menu enum (2 bits).
  - Keycode constants KEY_LEFT, KEY_RIGHT, KEY_Z, KEY_ENTER.
- Sub-module key_press_detect (Clk, Reset, keycode -> press, press_code): the registered prev_key edge detector, reused by the title and menu screens.

Test Plan:
- Reset, then battle_start -> phase=1, player_hp=20, enemy_hp=40, items_left=3, menu_sel=0.
- In MENU: Left once -> menu_sel=3; hold Right 10 cycles -> menu_sel=0, only one increment; Left then Right without release -> back to 3.
- FIGHT x7 with no hits -> enemy_hp steps 34, 28 … 4, then 0; on the 7th TEXT expiry phase=4 and battle_done pulses once.
- ITEM at player_hp=15 -> 20, items_left=2. ITEM four times -> items_left stays 0 and the 4th use leaves HP unchanged.
- ATTACK with player_hp=1: hit in the same cycle as the final frame_tick -> phase=6, not MENU; player_hp=0.
- MERCY at enemy_hp=16 -> no effect, goes to TEXT. At enemy_hp=10 -> phase=5. Assert Reset mid-ATTACK -> phase=0 and all outputs at reset values next cycle.
